uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer sitting directly downstream of the UART receiver. It captures each byte presented with the receiver's single-cycle `data_ready` pulse into a parameterised first-word-fall-through FIFO and exposes a valid/ready read port to the host bus logic. It also maintains a sticky overrun flag, a character-timeout detector clocked by the shared 16x baud tick, and a level interrupt request.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes; legal range 2..8.
- `THRESHOLD`, 8: `irq` asserts when `count >= THRESHOLD`; legal range 1..2^DEPTH_LOG2.
- `TIMEOUT_TICKS`, 640: 16x ticks of inactivity before `rx_timeout` asserts (640 = 4 character times at 8N1); legal range 1..4095.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `uart_tick_16x` in 1: 16x baud enable pulse, one `clock` cycle wide.
- `rx_data` in 8: received byte; sampled only when `rx_valid`=1.
- `rx_valid` in 1: single-cycle push pulse (receiver `data_ready`).
- `rd_data` out 8: head-of-FIFO byte; valid while `rd_valid`=1.
- `rd_valid` out 1: FIFO non-empty.
- `rd_ready` in 1: consumer accepts `rd_data` at this edge when `rd_valid`=1.
- `count` out DEPTH_LOG2+1: bytes currently stored, 0..2^DEPTH_LOG2.
- `full` out 1: `count == 2^DEPTH_LOG2`.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `overrun_clear` in 1: clears `overrun` at the next edge.
- `rx_timeout` out 1: FIFO non-empty and no push/pop for TIMEOUT_TICKS ticks.
- `irq` out 1: `(count >= THRESHOLD) | rx_timeout | overrun`, registered.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array. Write and read pointers are DEPTH_LOG2 bits and wrap modulo depth. `count` is a separate register.
- Push = `rx_valid & (~full | pop)`. Pop = `rd_valid & rd_ready`.
- Push writes `rx_data` at `wr_ptr` and increments it. Pop increments `rd_ptr`.
- `count` update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Full with simultaneous push and pop: both occur. The byte is accepted, `count` stays at depth, and no overrun is flagged.
- Full with push and no pop: the byte is dropped, `overrun` sets to 1, and FIFO contents are untouched.
- Empty: `rd_valid`=0, so `rd_ready` is ignored and no pop occurs. `rd_data` is don't-care; it reads `mem[rd_ptr]` combinationally.
- `overrun` priority: a set in the same cycle as `overrun_clear` wins, leaving `overrun`=1.
- Timeout counter (width 12):
  - Resets to 0 on any push, any pop, or while the FIFO is empty.
  - Otherwise increments on each `uart_tick_16x` and saturates at TIMEOUT_TICKS.
  - `rx_timeout` = (counter == TIMEOUT_TICKS) & ~empty, registered.
  - It therefore drops the cycle after any push, pop, or transition to empty.
- Reset (`reset_n`=0, asynchronous):
  - Pointers, `count`, and the timeout counter go to 0.
  - `rd_valid`, `full`, `overrun`, `rx_timeout`, and `irq` go to 0.
  - Array contents are not reset.
  - Reset mid-operation discards all buffered bytes. Deassertion is synchronised by the parent.

## Timing
- Push at edge N: `count`, `rd_valid`, `full`, and `rd_data` (if the FIFO was empty) update after edge N, i.e. visible in cycle N+1.
- Pop at edge N: the next byte appears on `rd_data` in cycle N+1. Back-to-back pops every cycle are supported.
- `irq` is registered from next-state values, so it is valid in the same cycle as the updated `count`/`overrun`/`rx_timeout`.
- Timeout: with the FIFO non-empty and idle, `rx_timeout` rises one cycle after the edge on which the TIMEOUT_TICKS-th tick is counted.
- All outputs are registered except `rd_data`, which is the combinational array read.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on separate pulses. Required: `count`=3, `rd_valid`=1, `rd_data`=0x41. Pop three times with `rd_ready` held at 1. Required: bytes 0x41, 0x42, 0x43 in order, then `rd_valid`=0.
- Push 16 bytes 0x00..0x0F (DEPTH_LOG2=4). Required: `full`=1 and `irq`=1 from the 8th byte onward. A 17th push of 0xFF sets `overrun`=1. Draining returns 0x00..0x0F with no 0xFF.
- Full FIFO, `rx_valid`=1 with `rd_ready`=1 in the same cycle. Required: pops 0x00, accepts the new byte, `count` stays 16, `overrun`=0.
- Push 20 and pop 20 interleaved across pointer wrap. Required: data order preserved, `count` never exceeds 16, `full` never spuriously set.
- One byte buffered, 640 ticks with no activity. Required: `rx_timeout`=1 and `irq`=1. One pop then clears both on the next cycle.
- Assert `reset_n`=0 asynchronously mid-stream with `count`=5 and `overrun`=1. Required: all outputs 0 immediately without a clock edge, and `count`=0 after release. `overrun_clear` on the same cycle as a dropped push leaves `overrun`=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : UART receive buffer with a first-word-fall-through FIFO, sticky
//            overrun flag, character timeout and level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int DEPTH_LOG2    = 4,
   parameter int THRESHOLD     = 8,
   parameter int TIMEOUT_TICKS = 640
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  uart_tick_16x,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  overrun,
   input  logic                  overrun_clear,
   output logic                  rx_timeout,
   output logic                  irq
);

   localparam int                  c_depth_int = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_depth     = (DEPTH_LOG2+1)'(c_depth_int);
   localparam logic [DEPTH_LOG2:0] c_threshold = (DEPTH_LOG2+1)'(THRESHOLD);
   localparam logic [DEPTH_LOG2:0] c_one       = (DEPTH_LOG2+1)'(1);
   localparam logic [11:0]         c_timeout   = 12'(TIMEOUT_TICKS);
   localparam logic [11:0]         c_tick_one  = 12'd1;

   logic [7:0]            r_mem [c_depth_int];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [11:0]           r_tcnt;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_drop;
   logic [DEPTH_LOG2:0]   w_count_nxt;
   logic [11:0]           w_tcnt_nxt;
   logic                  w_overrun_nxt;
   logic                  w_timeout_nxt;
   logic                  w_irq_nxt;

   // A full FIFO still accepts a byte when the head is popped on the same edge.
   always_comb begin
      w_pop  = rd_valid & rd_ready;
      w_push = rx_valid & (~full | w_pop);
      w_drop = rx_valid & ~w_push;
   end

   always_comb begin
      w_count_nxt = count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = count + c_one;
         2'b01:   w_count_nxt = count - c_one;
         default: w_count_nxt = count;
      endcase
   end

   // A drop outranks a simultaneous clear so no overrun event is ever lost.
   always_comb begin
      w_overrun_nxt = overrun;
      if (w_drop) begin
         w_overrun_nxt = 1'b1;
      end else if (overrun_clear) begin
         w_overrun_nxt = 1'b0;
      end
   end

   always_comb begin
      w_tcnt_nxt = r_tcnt;
      if (w_push | w_pop | ~rd_valid) begin
         w_tcnt_nxt = 12'd0;
      end else if (uart_tick_16x && (r_tcnt != c_timeout)) begin
         w_tcnt_nxt = r_tcnt + c_tick_one;
      end
      w_timeout_nxt = (w_tcnt_nxt == c_timeout) && (w_count_nxt != '0);
      w_irq_nxt     = (w_count_nxt >= c_threshold) | w_timeout_nxt | w_overrun_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_tcnt     <= '0;
         count      <= '0;
         rd_valid   <= 1'b0;
         full       <= 1'b0;
         overrun    <= 1'b0;
         rx_timeout <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_tcnt     <= w_tcnt_nxt;
         count      <= w_count_nxt;
         rd_valid   <= (w_count_nxt != '0);
         full       <= (w_count_nxt == c_depth);
         overrun    <= w_overrun_nxt;
         rx_timeout <= w_timeout_nxt;
         irq        <= w_irq_nxt;
      end
   end

   // Storage is left unreset; only pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   assign rd_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int DEPTH_LOG2    = 4;
   localparam int DEPTH         = 1 << DEPTH_LOG2;
   localparam int THRESHOLD     = 8;
   localparam int TIMEOUT_TICKS = 640;

   logic                clock = 1'b0;
   logic                reset_n;
   logic                uart_tick_16x;
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic [7:0]          rd_data;
   logic                rd_valid;
   logic                rd_ready;
   logic [DEPTH_LOG2:0] count;
   logic                full;
   logic                overrun;
   logic                overrun_clear;
   logic                rx_timeout;
   logic                irq;

   int checks = 0;
   int errors = 0;

   // Reference model: byte queue, sticky flag, ticks since last activity.
   byte unsigned m_q[$];
   bit           m_ov;
   int           m_idle;
   int           max_count;

   uart_rx_fifo #(
      .DEPTH_LOG2   (DEPTH_LOG2),
      .THRESHOLD    (THRESHOLD),
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .uart_tick_16x(uart_tick_16x),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .count        (count),
      .full         (full),
      .overrun      (overrun),
      .overrun_clear(overrun_clear),
      .rx_timeout   (rx_timeout),
      .irq          (irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      bit exp_to;
      exp_to = (m_idle == TIMEOUT_TICKS) && (m_q.size() > 0);
      check({tag, ".count"},      32'(count),      32'(m_q.size()));
      check({tag, ".rd_valid"},   32'(rd_valid),   32'(m_q.size() > 0));
      check({tag, ".full"},       32'(full),       32'(m_q.size() == DEPTH));
      check({tag, ".overrun"},    32'(overrun),    32'(m_ov));
      check({tag, ".rx_timeout"}, 32'(rx_timeout), 32'(exp_to));
      check({tag, ".irq"},        32'(irq),
            32'((m_q.size() >= THRESHOLD) || exp_to || m_ov));
      if (m_q.size() > 0) begin
         check({tag, ".rd_data"}, 32'(rd_data), 32'(m_q[0]));
      end
   endtask

   // One clock cycle of stimulus with the model advanced by the rules of the block.
   task automatic step(input string tag, input bit v, input byte unsigned d,
                       input bit rr, input bit tk, input bit oc);
      bit pop, push, was_empty;
      rx_valid      = v;
      rx_data       = d;
      rd_ready      = rr;
      uart_tick_16x = tk;
      overrun_clear = oc;
      was_empty = (m_q.size() == 0);
      pop  = !was_empty && rr;
      push = v && ((m_q.size() < DEPTH) || pop);
      @(posedge clock);
      #1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(d);
      if (v && !push)  m_ov = 1'b1;
      else if (oc)     m_ov = 1'b0;
      if (push || pop || was_empty) m_idle = 0;
      else if (tk && m_idle < TIMEOUT_TICKS) m_idle++;
      if (m_q.size() > max_count) max_count = m_q.size();
      rx_valid      = 1'b0;
      rd_ready      = 1'b0;
      uart_tick_16x = 1'b0;
      overrun_clear = 1'b0;
      check_outputs(tag);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ov   = 1'b0;
      m_idle = 0;
   endtask

   initial begin
      reset_n       = 1'b0;
      uart_tick_16x = 1'b0;
      rx_data       = 8'h00;
      rx_valid      = 1'b0;
      rd_ready      = 1'b0;
      overrun_clear = 1'b0;
      max_count     = 0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_outputs("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // Three separate pushes, then drain with rd_ready held high.
      step("push41", 1, 8'h41, 0, 0, 0);
      step("idle",   0, 8'h00, 0, 0, 0);
      step("push42", 1, 8'h42, 0, 0, 0);
      step("idle",   0, 8'h00, 0, 0, 0);
      step("push43", 1, 8'h43, 0, 0, 0);
      check("three.count",   32'(count),   32'd3);
      check("three.rd_data", 32'(rd_data), 32'h41);
      step("pop1", 0, 8'h00, 1, 0, 0);
      check("pop1.data", 32'(rd_data), 32'h42);
      step("pop2", 0, 8'h00, 1, 0, 0);
      check("pop2.data", 32'(rd_data), 32'h43);
      step("pop3", 0, 8'h00, 1, 0, 0);
      check("pop3.rd_valid", 32'(rd_valid), 32'd0);

      // Fill to depth, then overflow with 0xFF.
      for (int i = 0; i < DEPTH; i++) begin
         step("fill", 1, 8'(i), 0, 0, 0);
         if (i >= THRESHOLD - 1) check("fill.irq", 32'(irq), 32'd1);
      end
      check("fill.full", 32'(full), 32'd1);
      step("ovf", 1, 8'hFF, 0, 0, 0);
      check("ovf.overrun", 32'(overrun), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         check("drain.data", 32'(rd_data), 32'(i));
         step("drain", 0, 8'h00, 1, 0, 0);
      end
      check("drain.empty", 32'(rd_valid), 32'd0);
      step("ovclr", 0, 8'h00, 0, 0, 1);
      check("ovclr.overrun", 32'(overrun), 32'd0);

      // Full FIFO with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++) step("fill2", 1, 8'(i), 0, 0, 0);
      step("pushpop", 1, 8'hAA, 1, 0, 0);
      check("pushpop.count",   32'(count),   32'(DEPTH));
      check("pushpop.overrun", 32'(overrun), 32'd0);
      check("pushpop.rd_data", 32'(rd_data), 32'h01);
      while (m_q.size() > 0) step("drain2", 0, 8'h00, 1, 0, 0);

      // Random interleaved traffic across pointer wrap.
      max_count = 0;
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 7) == 0));
      end
      check("rand.max_count", 32'(max_count <= DEPTH), 32'd1);
      while (m_q.size() > 0) step("drain3", 0, 8'h00, 1, 0, 0);
      step("ovclr2", 0, 8'h00, 0, 0, 1);

      // Character timeout with one byte buffered.
      step("tpush", 1, 8'h5A, 0, 0, 0);
      for (int i = 0; i < TIMEOUT_TICKS; i++) step("tick", 0, 8'h00, 0, 1, 0);
      check("timeout.rx_timeout", 32'(rx_timeout), 32'd1);
      check("timeout.irq",        32'(irq),        32'd1);
      step("tpop", 0, 8'h00, 1, 1, 0);
      check("tpop.rx_timeout", 32'(rx_timeout), 32'd0);
      check("tpop.irq",        32'(irq),        32'd0);

      // Drop and clear on the same edge: the drop wins.
      for (int i = 0; i < DEPTH; i++) step("fill3", 1, 8'(i + 16), 0, 0, 0);
      step("dropclr", 1, 8'hEE, 0, 0, 1);
      check("dropclr.overrun", 32'(overrun), 32'd1);
      for (int i = 0; i < DEPTH - 5; i++) step("pop5", 0, 8'h00, 1, 0, 0);
      check("pre_rst.count", 32'(count), 32'd5);

      // Asynchronous reset between clock edges.
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      step("post_rst", 0, 8'h00, 0, 0, 0);
      check("post_rst.count", 32'(count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
